// File: rtl/distance_filter_if.sv
// Sensor-side and decode-side signals of the distance filter, bundled for port hookup.
interface distance_filter_if #(parameter int W = 22);
  logic         ready;
  logic [W-1:0] distance_raw;
  logic [W-1:0] dist_avg;
  logic [1:0]   zone;
  logic         avg_valid;
  logic         filled;
  logic         stale;

  modport master (output ready, distance_raw,
                  input  dist_avg, zone, avg_valid, filled, stale);
  modport slave  (input  ready, distance_raw,
                  output dist_avg, zone, avg_valid, filled, stale);
endinterface

// File: rtl/distance_filter.sv
// Range check, power-of-two moving average and hysteretic zone classification
// of HC-SR04 distance samples; capture -> buffer -> output in three stages.
module distance_filter #(
  parameter int W          = 22,
  parameter int DEPTH_LOG2 = 2,
  parameter int SAFE_TH    = 1000,
  parameter int WARN_TH    = 500,
  parameter int HYST       = 50,
  parameter int MAX_RAW    = 23200,
  parameter int STALE_N    = 3
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  distance_filter_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SW    = W + DEPTH_LOG2;
  localparam int WP    = W + 1;
  localparam int RW    = $clog2(STALE_N + 1);
  localparam int STAGES = 2;

  localparam logic [WP-1:0] SAFE_UP = WP'(SAFE_TH + HYST);
  localparam logic [WP-1:0] WARN_UP = WP'(WARN_TH + HYST);
  localparam logic [WP-1:0] SAFE_LO = WP'(SAFE_TH);
  localparam logic [WP-1:0] WARN_LO = WP'(WARN_TH);
  localparam logic [W-1:0]  MAX_V   = W'(MAX_RAW);
  localparam logic [RW-1:0] REJ_MAX = RW'(STALE_N);
  localparam logic [RW-1:0] REJ_ONE = RW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {DANGER = 2'd0, WARNING = 2'd1, SAFE = 2'd2} zone_t;

  logic                         r_ready_d;
  logic [STAGES:0]              r_vld_pipe;
  logic [W-1:0]                 r_cap;
  logic                         r_cap_bad;
  logic [DEPTH-1:0][W-1:0]      r_buf;
  logic [SW-1:0]                r_sum;
  logic [DEPTH_LOG2-1:0]        r_wr_ptr;
  logic                         r_filled;
  logic [RW-1:0]                r_rej;
  logic                         r_stale;
  logic [W-1:0]                 r_avg;
  zone_t                        r_zone;
  zone_t                        w_zone_nxt;
  logic                         w_cap;
  logic [W-1:0]                 w_avg_new;
  logic [WP-1:0]                w_a;

  assign w_cap     = bus.ready & ~r_ready_d;
  assign w_avg_new = W'(r_sum >> DEPTH_LOG2);
  assign w_a       = {1'b0, w_avg_new};

  // Stage 1 only forwards accepted samples, so rejects never strobe avg_valid.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[1], r_vld_pipe[0] & ~r_cap_bad, w_cap};
  end

  // ready_d resets high so a ready level held through reset is not an edge.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_d <= 1'b1;
      r_cap     <= '0;
      r_cap_bad <= 1'b0;
    end else begin
      r_ready_d <= bus.ready;
      if (w_cap) begin
        r_cap     <= bus.distance_raw;
        r_cap_bad <= (bus.distance_raw == '0) || (bus.distance_raw > MAX_V);
      end
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_filled <= 1'b0;
      r_rej    <= '0;
      r_stale  <= 1'b0;
    end else if (r_vld_pipe[0]) begin
      if (!r_cap_bad) begin
        r_rej   <= '0;
        r_stale <= 1'b0;
        if (!r_filled) begin
          for (int i = 0; i < DEPTH; i++) r_buf[i] <= r_cap;
          r_sum    <= SW'(r_cap) << DEPTH_LOG2;
          r_wr_ptr <= PTR_ONE;
          r_filled <= 1'b1;
        end else begin
          r_sum           <= r_sum + SW'(r_cap) - SW'(r_buf[r_wr_ptr]);
          r_buf[r_wr_ptr] <= r_cap;
          r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        end
      end else begin
        if (r_rej != REJ_MAX) r_rej <= r_rej + REJ_ONE;
        if (r_rej >= REJ_MAX - REJ_ONE) r_stale <= 1'b1;
      end
    end
  end

  always_comb begin
    w_zone_nxt = DANGER;
    case (r_zone)
      DANGER:  w_zone_nxt = (w_a >= SAFE_UP) ? SAFE :
                            (w_a >= WARN_UP) ? WARNING : DANGER;
      WARNING: w_zone_nxt = (w_a >= SAFE_UP) ? SAFE :
                            (w_a <  WARN_LO) ? DANGER : WARNING;
      SAFE:    w_zone_nxt = (w_a <  WARN_LO) ? DANGER :
                            (w_a <  SAFE_LO) ? WARNING : SAFE;
      default: w_zone_nxt = DANGER;
    endcase
  end

  // While stale the held zone is parked at DANGER so evaluation restarts there.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_avg  <= '0;
      r_zone <= DANGER;
    end else if (r_vld_pipe[1]) begin
      r_avg  <= w_avg_new;
      r_zone <= w_zone_nxt;
    end else if (r_stale) begin
      r_zone <= DANGER;
    end
  end

  assign bus.dist_avg  = r_avg;
  assign bus.zone      = r_stale ? DANGER : r_zone;
  assign bus.avg_valid = r_vld_pipe[STAGES];
  assign bus.filled    = r_filled;
  assign bus.stale     = r_stale;
endmodule

// File: tb/tb_distance_filter.sv
// Bench for distance_filter: directed test-plan scenarios plus randomized samples
// checked against a window-average/zone-rule reference model.
`timescale 1ns/1ps
module tb_distance_filter;
  localparam int W = 22;
  localparam int DEPTH = 4;
  localparam int SAFE_TH = 1000, WARN_TH = 500, HYST = 50, MAX_RAW = 23200, STALE_N = 3;

  logic clk_1MHz = 1'b0;
  logic rst_n    = 1'b0;
  int   tests = 0, fails = 0;

  distance_filter_if #(.W(W)) dif ();
  distance_filter #(.W(W)) dut (.clk_1MHz(clk_1MHz), .rst_n(rst_n), .bus(dif));

  always #500 clk_1MHz = ~clk_1MHz;

  // reference model
  int m_win[DEPTH];
  int m_ptr, m_zone, m_rej, m_avg;
  bit m_filled, m_stale;

  function automatic int next_zone(int z, int a);
    case (z)
      0:       return (a >= SAFE_TH + HYST) ? 2 : (a >= WARN_TH + HYST) ? 1 : 0;
      1:       return (a >= SAFE_TH + HYST) ? 2 : (a < WARN_TH) ? 0 : 1;
      2:       return (a < WARN_TH) ? 0 : (a < SAFE_TH) ? 1 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_zone();
    return m_stale ? 0 : m_zone;
  endfunction

  task automatic model_reset();
    foreach (m_win[i]) m_win[i] = 0;
    m_ptr = 0; m_zone = 0; m_rej = 0; m_avg = 0; m_filled = 0; m_stale = 0;
  endtask

  task automatic model_apply(input int raw, output bit ev);
    int s;
    if (raw == 0 || raw > MAX_RAW) begin
      ev = 0;
      if (m_rej < STALE_N) m_rej++;
      if (m_rej == STALE_N) begin m_stale = 1; m_zone = 0; end
    end else begin
      ev = 1; m_rej = 0; m_stale = 0;
      if (!m_filled) begin
        foreach (m_win[i]) m_win[i] = raw;
        m_filled = 1;
      end else m_win[m_ptr] = raw;
      m_ptr = (m_ptr + 1) % DEPTH;
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_avg  = s / DEPTH;
      m_zone = next_zone(m_zone, m_avg);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_1MHz);
    dif.ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
  endtask

  // One capture; reports strobe offset (negedges after capture edge) and settled outputs.
  task automatic drive_sample(input int raw, output int lat, output int nstb,
                              output int av, output int z, output bit f, output bit s);
    lat = -1; nstb = 0;
    @(negedge clk_1MHz);
    dif.distance_raw = W'(raw);
    dif.ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_1MHz);
      if (c == 0) dif.ready = 1'b0;
      if (dif.avg_valid) begin nstb++; if (lat < 0) lat = c - 0; end
    end
    av = int'(dif.dist_avg); z = int'(dif.zone); f = dif.filled; s = dif.stale;
  endtask

  task automatic test_reset();
    int lat, nstb, av, z; bit f, s, ev;
    dif.ready = 1'b1; dif.distance_raw = W'(1200); rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_1MHz);
    tests++;
    if ({dif.dist_avg, dif.zone, dif.avg_valid, dif.filled, dif.stale} !== '0) begin
      fails++; $display("FAIL reset_values got avg=%0d zone=%0d v=%0b f=%0b s=%0b want all 0",
                        dif.dist_avg, dif.zone, dif.avg_valid, dif.filled, dif.stale);
    end
    rst_n = 1'b1;
    nstb = 0;
    repeat (6) begin @(negedge clk_1MHz); if (dif.avg_valid) nstb++; end
    tests++;
    if (nstb != 0 || dif.filled !== 1'b0) begin
      fails++; $display("FAIL ready_held_release got strobes=%0d filled=%0b want 0,0", nstb, dif.filled);
    end
    dif.ready = 1'b0;
    @(negedge clk_1MHz);
    model_apply(1200, ev);
    drive_sample(1200, lat, nstb, av, z, f, s);
    tests++;
    if (lat != 2 || nstb != 1) begin
      fails++; $display("FAIL first_latency got lat=%0d n=%0d want 2,1", lat, nstb);
    end
    tests++;
    if (av != 1200 || z != 2 || f !== 1'b1 || s !== 1'b0) begin
      fails++; $display("FAIL first_sample got avg=%0d zone=%0d f=%0b s=%0b want 1200,2,1,0", av, z, f, s);
    end
  endtask

  task automatic test_sequences();
    int seq[] = '{1200, 800, 800, 800, 800, -1, 700, 1020, 1020, 1020, 1020, 1050, 1050, 1050, 1050};
    int lat, nstb, av, z; bit f, s, ev;
    do_reset();
    foreach (seq[i]) begin
      if (seq[i] < 0) begin do_reset(); continue; end
      model_apply(seq[i], ev);
      drive_sample(seq[i], lat, nstb, av, z, f, s);
      tests++;
      if (lat != 2 || nstb != 1) begin
        fails++; $display("FAIL seq_strobe[%0d] got lat=%0d n=%0d want 2,1", i, lat, nstb);
      end
      tests++;
      if (av != m_avg || z != exp_zone()) begin
        fails++; $display("FAIL seq_avg[%0d] raw=%0d got avg=%0d zone=%0d want %0d,%0d",
                          i, seq[i], av, z, m_avg, exp_zone());
      end
    end
    tests++;
    if (av != 1050 || z != 2) begin
      fails++; $display("FAIL hyst_final got avg=%0d zone=%0d want 1050,2", av, z);
    end
  endtask

  task automatic test_stale();
    int seq[] = '{1200, 0, 30000, 0, 1200, 23201, 23200, 1};
    int lat, nstb, av, z; bit f, s, ev;
    do_reset();
    foreach (seq[i]) begin
      model_apply(seq[i], ev);
      drive_sample(seq[i], lat, nstb, av, z, f, s);
      tests++;
      if (ev ? (lat != 2 || nstb != 1) : (nstb != 0)) begin
        fails++; $display("FAIL stale_strobe[%0d] raw=%0d got lat=%0d n=%0d want valid=%0b", i, seq[i], lat, nstb, ev);
      end
      tests++;
      if (av != m_avg || z != exp_zone() || s !== m_stale || f !== m_filled) begin
        fails++; $display("FAIL stale_state[%0d] raw=%0d got avg=%0d zone=%0d s=%0b f=%0b want %0d,%0d,%0b,%0b",
                          i, seq[i], av, z, s, f, m_avg, exp_zone(), m_stale, m_filled);
      end
      if (i == 3) begin
        tests++;
        if (s !== 1'b1 || z != 0 || av != 1200) begin
          fails++; $display("FAIL stale_set got s=%0b zone=%0d avg=%0d want 1,0,1200", s, z, av);
        end
      end
    end
  endtask

  task automatic test_reset_midpipe();
    int lat, nstb, av, z; bit f, s, ev;
    do_reset();
    model_apply(1200, ev);
    drive_sample(1200, lat, nstb, av, z, f, s);
    @(negedge clk_1MHz);
    dif.distance_raw = W'(600); dif.ready = 1'b1;
    @(negedge clk_1MHz);
    dif.ready = 1'b0; rst_n = 1'b0;
    #1;
    tests++;
    if ({dif.dist_avg, dif.zone, dif.avg_valid, dif.filled, dif.stale} !== '0) begin
      fails++; $display("FAIL midpipe_reset got avg=%0d zone=%0d v=%0b f=%0b s=%0b want all 0",
                        dif.dist_avg, dif.zone, dif.avg_valid, dif.filled, dif.stale);
    end
    nstb = 0;
    repeat (3) begin @(negedge clk_1MHz); if (dif.avg_valid) nstb++; end
    rst_n = 1'b1; model_reset();
    repeat (3) begin @(negedge clk_1MHz); if (dif.avg_valid) nstb++; end
    tests++;
    if (nstb != 0) begin fails++; $display("FAIL midpipe_no_strobe got %0d want 0", nstb); end
    model_apply(300, ev);
    drive_sample(300, lat, nstb, av, z, f, s);
    tests++;
    if (lat != 2 || av != 300 || z != 0 || f !== 1'b1) begin
      fails++; $display("FAIL midpipe_refill got lat=%0d avg=%0d zone=%0d f=%0b want 2,300,0,1", lat, av, z, f);
    end
  endtask

  task automatic test_back_to_back();
    int smp[] = '{400, 800, 1200, 1600};
    int got[$], want[$], zg[$], zw[$];
    int lat, nstb, av, z, idx; bit f, s, ev;
    do_reset();
    model_apply(400, ev);
    drive_sample(400, lat, nstb, av, z, f, s);
    foreach (smp[i]) begin model_apply(smp[i], ev); want.push_back(m_avg); zw.push_back(m_zone); end
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_1MHz);
      if (dif.avg_valid) begin got.push_back(int'(dif.dist_avg)); zg.push_back(int'(dif.zone)); end
      if (c % 2 == 0 && idx < 4) begin
        dif.distance_raw = W'(smp[idx]); dif.ready = 1'b1; idx++;
      end else dif.ready = 1'b0;
    end
    tests++;
    if (got.size() != 4) begin
      fails++; $display("FAIL b2b_count got %0d want 4", got.size());
    end else begin
      foreach (want[i]) begin
        tests++;
        if (got[i] != want[i] || zg[i] != zw[i]) begin
          fails++; $display("FAIL b2b_avg[%0d] got avg=%0d zone=%0d want %0d,%0d", i, got[i], zg[i], want[i], zw[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int raw, lat, nstb, av, z, r; bit f, s, ev;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      raw = 0;
      else if (r == 1) raw = MAX_RAW + 1 + $urandom_range(0, 10000);
      else if (r < 7)  raw = $urandom_range(300, 1300);
      else             raw = $urandom_range(1, MAX_RAW);
      model_apply(raw, ev);
      drive_sample(raw, lat, nstb, av, z, f, s);
      tests++;
      if ((ev ? (lat != 2 || nstb != 1) : (nstb != 0)) ||
          av != m_avg || z != exp_zone() || s !== m_stale || f !== m_filled) begin
        fails++; $display("FAIL random[%0d] raw=%0d got lat=%0d n=%0d avg=%0d zone=%0d s=%0b f=%0b want valid=%0b avg=%0d zone=%0d s=%0b f=%0b",
                          n, raw, lat, nstb, av, z, s, f, ev, m_avg, exp_zone(), m_stale, m_filled);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_stale();
    test_reset_midpipe();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
